// File: rtl/ctrl_tx.sv
// ctrl_tx: framed 8N1 transmitter (SYNC, N_CH channel bytes, optional checksum)
// Ports: clk, reset_n, in_data[8*N_CH], go -> busy, done, TX; option CTRL_TX_CHECKSUM_EN
module ctrl_tx #(
  parameter int         N_CH = 7,
  parameter int         fCLK = 50_000_000,
  parameter int         BAUD = 115_200,
  parameter logic [7:0] SYNC = 8'hA5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [8*N_CH-1:0] in_data,
  input  logic              go,
  output logic              busy,
  output logic              done,
  output logic              TX
);

  localparam int BIT_CYCLES = fCLK / BAUD;
  localparam int BW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int IW = $clog2(N_CH + 2);
`ifdef CTRL_TX_CHECKSUM_EN
  localparam int LAST = N_CH + 1;
`else
  localparam int LAST = N_CH;
`endif

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                 state, state_n;
  logic [BW-1:0]          baud, baud_n;
  logic [2:0]             bitc, bitc_n;
  logic [IW-1:0]          idx, idx_n;
  logic [N_CH-1:0][7:0]   shadow, shadow_n;
  logic [7:0]             cur_byte;
  logic                   baud_end;
  logic                   tx_n, busy_n, done_n;
`ifdef CTRL_TX_CHECKSUM_EN
  logic [7:0]             csum, csum_n;
`endif

  assign baud_end = (baud == BW'(BIT_CYCLES - 1));

  // Byte index 0 is SYNC, 1..N_CH the channels, N_CH+1 the checksum.
  always_comb begin
    cur_byte = SYNC;
    for (int k = 0; k < N_CH; k++)
      if (idx == IW'(k + 1))
        cur_byte = shadow[k];
`ifdef CTRL_TX_CHECKSUM_EN
    if (idx == IW'(N_CH + 1))
      cur_byte = csum;
`endif
  end

  always_comb begin
    state_n  = state;
    baud_n   = baud;
    bitc_n   = bitc;
    idx_n    = idx;
    shadow_n = shadow;
    done_n   = 1'b0;
`ifdef CTRL_TX_CHECKSUM_EN
    csum_n   = csum;
`endif
    case (state)
      IDLE: begin
        baud_n = '0;
        if (go) begin
          shadow_n = in_data;
          idx_n    = '0;
          bitc_n   = '0;
          state_n  = START;
`ifdef CTRL_TX_CHECKSUM_EN
          csum_n   = '0;
`endif
        end
      end
      START: begin
        baud_n = baud + 1'b1;
        if (baud_end) begin
          baud_n  = '0;
          bitc_n  = '0;
          state_n = DATA;
        end
      end
      DATA: begin
        baud_n = baud + 1'b1;
        if (baud_end) begin
          baud_n = '0;
          bitc_n = bitc + 1'b1;
          if (bitc == 3'd7)
            state_n = STOP;
        end
      end
      STOP: begin
        baud_n = baud + 1'b1;
        if (baud_end) begin
          baud_n = '0;
          if (idx == IW'(LAST)) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end else begin
            idx_n   = idx + 1'b1;
            state_n = START;
`ifdef CTRL_TX_CHECKSUM_EN
            // The channel about to be sent is shadow[idx].
            for (int k = 0; k < N_CH; k++)
              if (idx == IW'(k))
                csum_n = csum + shadow[k];
`endif
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // Outputs are computed from the next state so the flops
    // present them in the same cycle the state takes effect.
    busy_n = (state_n != IDLE);
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = cur_byte[bitc_n];
      default: tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      baud   <= '0;
      bitc   <= '0;
      idx    <= '0;
      shadow <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      TX     <= 1'b1;
`ifdef CTRL_TX_CHECKSUM_EN
      csum   <= '0;
`endif
    end else begin
      state  <= state_n;
      baud   <= baud_n;
      bitc   <= bitc_n;
      idx    <= idx_n;
      shadow <= shadow_n;
      busy   <= busy_n;
      done   <= done_n;
      TX     <= tx_n;
`ifdef CTRL_TX_CHECKSUM_EN
      csum   <= csum_n;
`endif
    end
  end

endmodule

// File: tb/tb_ctrl_tx.sv
// tb_ctrl_tx: directed bench for ctrl_tx with an 8N1 decoder and byte scoreboard
// Runs at BIT_CYCLES=10, N_CH=7; honours CTRL_TX_CHECKSUM_EN
module tb_ctrl_tx;

  localparam int N_CH = 7;
  localparam int BC   = 10;
`ifdef CTRL_TX_CHECKSUM_EN
  localparam int C = 1;
`else
  localparam int C = 0;
`endif
  localparam int F = (N_CH + 1 + C) * 10 * BC;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              go = 1'b0;
  logic [8*N_CH-1:0] in_data = '0;
  logic              busy, done, TX;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_q[$];
  int done_cnt = 0;
  int busy_cyc = 0;

  ctrl_tx #(
    .N_CH(N_CH),
    .fCLK(1_000_000),
    .BAUD(100_000),
    .SYNC(8'hA5)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .in_data(in_data),
    .go(go),
    .busy(busy),
    .done(done),
    .TX(TX)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (busy === 1'b1) busy_cyc++;
  end

  // 8N1 decoder sampling mid-bit; each byte is scored against the queue.
  bit         rx_on = 1'b0;
  int         rx_cnt = 0;
  int         pos;
  logic [7:0] rx_sh;
  always @(negedge clk) begin
    if (!reset_n) begin
      rx_on  = 1'b0;
      rx_cnt = 0;
    end else if (!rx_on) begin
      if (TX === 1'b0) begin
        rx_on  = 1'b1;
        rx_cnt = 1;
      end
    end else begin
      rx_cnt++;
      if (rx_cnt % BC == BC / 2) begin
        pos = rx_cnt / BC;
        if (pos >= 1 && pos <= 8)
          rx_sh[pos-1] = TX;
        else if (pos == 9) begin
          check("stop_bit", {31'd0, TX}, 32'd1);
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $error("FAIL extra_byte: observed %0h expected none", rx_sh);
          end else
            check("rx_byte", {24'd0, rx_sh}, {24'd0, exp_q.pop_front()});
          rx_on = 1'b0;
        end
      end
    end
  end

  task automatic push_frame(input logic [8*N_CH-1:0] d);
    logic [7:0] s;
    s = 8'h00;
    exp_q.push_back(8'hA5);
    for (int k = 0; k < N_CH; k++) begin
      exp_q.push_back(d[8*k +: 8]);
      s = s + d[8*k +: 8];
    end
    if (C == 1) exp_q.push_back(s);
  endtask

  task automatic wait_done(output int k);
    k = 1;
    while (done !== 1'b1 && k < 4000) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic run_frame(input logic [8*N_CH-1:0] d);
    int k, b0, d0;
    push_frame(d);
    @(negedge clk);
    b0 = busy_cyc;
    d0 = done_cnt;
    in_data = d;
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    check("start_busy", {31'd0, busy}, 32'd1);
    check("start_tx", {31'd0, TX}, 32'd0);
    wait_done(k);
    check("done_cycle", k, F + 1);
    check("end_busy", {31'd0, busy}, 32'd0);
    check("end_tx", {31'd0, TX}, 32'd1);
    check("busy_cycles", busy_cyc - b0, F);
    check("q_drained", exp_q.size(), 32'd0);
    @(negedge clk);
    check("done_width", {31'd0, done}, 32'd0);
    check("done_count", done_cnt - d0, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, d0;
    logic [8*N_CH-1:0] d1, d2;

    repeat (3) @(negedge clk);
    check("rst_tx", {31'd0, TX}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    reset_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check("idle_tx", {31'd0, TX}, 32'd1);
      check("idle_busy", {31'd0, busy}, 32'd0);
      check("idle_done", {31'd0, done}, 32'd0);
    end

    run_frame(56'h07_06_05_04_03_02_01);
    run_frame({N_CH{8'hFF}});
    run_frame(56'h80_01_7E_C3_00_5A_3C);

    // go held high; in_data changed mid-frame; go toggled while busy.
    d1 = 56'h11_22_33_44_55_66_77;
    d2 = 56'hA0_B1_C2_D3_E4_F5_06;
    d0 = done_cnt;
    push_frame(d1);
    @(negedge clk);
    in_data = d1;
    go = 1'b1;
    @(negedge clk);
    check("hold_busy", {31'd0, busy}, 32'd1);
    repeat (300) @(negedge clk);
    in_data = d2;
    push_frame(d2);
    wait_done(k);
    check("hold_done_cycle", k, F + 1 - 300);
    @(negedge clk);
    check("b2b_busy", {31'd0, busy}, 32'd1);
    check("b2b_tx", {31'd0, TX}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      repeat (37) @(negedge clk);
      go = 1'b0;
      @(negedge clk);
      go = 1'b1;
    end
    go = 1'b0;
    wait_done(k);
    check("b2b_q_drained", exp_q.size(), 32'd0);
    repeat (50) @(negedge clk);
    check("b2b_idle", {31'd0, busy}, 32'd0);
    check("b2b_done_count", done_cnt - d0, 32'd2);

    // Reset at cycle 350 of a frame.
    push_frame(56'h01_02_03_04_05_06_07);
    @(negedge clk);
    in_data = 56'h01_02_03_04_05_06_07;
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    repeat (349) @(negedge clk);
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    d0 = done_cnt;
    #2 reset_n = 1'b0;
    #1;
    check("abort_tx", {31'd0, TX}, 32'd1);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    check("abort_no_done", done_cnt - d0, 32'd0);
    run_frame(56'hDE_AD_BE_EF_12_34_56);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ctrl_tx.md
# ctrl_tx

Serial transmitter for the analog-controls link: the sending end of the framed 8N1 stream carried on a CTRL_RX line and decoded by `a_ctrls`. It latches N_CH control bytes from a parallel bus on a `go` strobe. It then shifts them out on a single idle-high line as a sync byte, the channel bytes and an optional checksum. It sits on the control-panel board or in loopback test fabric, clocked from the 50 MHz domain.

## Interface
- N_CH, 7, number of channel bytes per frame (≥1)
- fCLK, 50_000_000, clock frequency in Hz
- BAUD, 115_200, line bit rate; BIT_CYCLES = fCLK/BAUD (integer division, 434 at defaults, must be ≥2)
- SYNC, 8'hA5, frame header byte

Ports:
- clk  in  1  system clock; single clock domain
- reset_n  in  1  reset, asynchronous, active-low
- in_data  in  8*N_CH  channel bytes; channel k = in_data[8k+7:8k], channel 0 sent first
- go  in  1  start request, sampled on clk
- busy  out  1  high while a frame is in flight
- done  out  1  one-cycle pulse at end of frame
- TX  out  1  serial line, idle high

## Operation
- States: IDLE, START, DATA, STOP.
- IDLE:
  - TX=1, busy=0.
  - On `go`=1: latch in_data into the shadow register; clear the checksum accumulator; select byte index 0, which is SYNC; go to START.
- START: TX=0 for BIT_CYCLES cycles, then go to DATA with bit counter 0.
- DATA:
  - TX = current byte bit[bitcnt], LSB first, each bit for BIT_CYCLES cycles.
  - After bit 7, go to STOP.
- STOP:
  - TX=1 for BIT_CYCLES cycles.
  - If more bytes remain, increment byte index and go to START (no inter-byte gap).
  - Otherwise go to IDLE and pulse `done`.
- Byte sequence:
  - SYNC, then ch0..ch(N_CH-1).
  - With the checksum enabled, a checksum byte follows last.
- Checksum:
  - Sum of the channel bytes, mod 256; SYNC is excluded.
  - Accumulated in an 8-bit register as each channel byte is loaded.
- `go` while busy=1 is ignored. No queuing.
- in_data changes while busy do not affect the frame in flight.
- Internal counters:
  - Baud counter is ⌈log2(BIT_CYCLES)⌉ bits and wraps to 0 at BIT_CYCLES-1.
  - Byte index is ⌈log2(N_CH+2)⌉ bits.

## Timing
- Reset values: TX=1, busy=0, done=0, state IDLE, all counters 0.
- Reset asserted mid-frame forces TX high immediately (asynchronous) and aborts the frame; no `done` is issued.
- Start of frame: `go` high at edge n → busy=1 and TX=0 from edge n+1.
- Frame length: F = (N_CH+1+C)·10·BIT_CYCLES cycles, where C=1 with the checksum and C=0 without. Each byte is 1 start + 8 data + 1 stop.
- End of frame: the last stop bit occupies edges n+F-BIT_CYCLES+1 … n+F. At edge n+F+1:
  - busy=0 and done=1 for exactly one cycle;
  - a `go` sampled on that same edge starts the next frame at n+F+2, so the minimum back-to-back idle is one cycle of TX=1 beyond the stop bit.
- All outputs are registered; TX has no combinational path from inputs.

## Configuration
- CTRL_TX_CHECKSUM_EN
  - Defined: the checksum byte is appended after the last channel, and the frame is N_CH+2 bytes.
  - Undefined: the checksum register and logic are removed, and the frame is N_CH+1 bytes (SYNC plus channels).

## Test plan
All scenarios use fCLK=1_000_000 and BAUD=100_000 (BIT_CYCLES=10) with N_CH=7 unless noted.

1. Reset, then idle 100 cycles → TX=1, busy=0, done=0 throughout.
2. in_data bytes 0x01..0x07 (ch0=0x01), one `go` pulse, CTRL_TX_CHECKSUM_EN defined:
   - decoded bytes are A5 01 02 03 04 05 06 07 1C;
   - busy high for 900 cycles;
   - single `done` pulse on cycle 901 after `go`.
3. Same stimulus with CTRL_TX_CHECKSUM_EN undefined → bytes A5 01..07, busy for 800 cycles.
4. Checksum wrap: all channels 0xFF → checksum byte 0xF9 (1785 mod 256).
5. `go` held high continuously; in_data changed mid-frame:
   - the first frame carries the latched values unaltered;
   - the second frame starts one idle cycle after `done`;
   - `go` pulses during busy produce no extra frames.
6. reset_n low at cycle 350 of a frame → TX=1 in the same cycle, busy=0, no `done`; a subsequent `go` yields a complete, correct frame.
